// File: rtl/cla_unmask_decoder.sv
// Receive-side unmask path: recovers a = (s - b - c) ^ k with a bit-serial
// ripple-borrow subtractor (one bit per clock, LSB first), returned over valid/ready.
module cla_unmask_decoder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   s,
  input  logic [W-1:0] b,
  input  logic         c,
  input  logic [W-1:0] k,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] enca,
  output logic         range_err
);

  // Handshake: a request transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Data is
  // sampled only at the transfer edge and out_valid never drops without a transfer.

  localparam int IW = $clog2(W + 1);
  localparam logic [IW-1:0] LAST = IW'(W);

  typedef enum logic [1:0] {IDLE, SUB, UNMASK, DONE} state_t;

  state_t        state;
  logic [W:0]    s_q;
  logic [W:0]    b_q;   // carries a constant 0 in bit W so the top stage sees bi = 0
  logic [W-1:0]  k_q;
  logic          borrow;
  logic [IW-1:0] idx;
  logic [W:0]    d_q;

  logic bi;
  logic si;
  logic d_bit;
  logic borrow_nxt;

  assign in_ready = (state == IDLE);

  always_comb begin
    si         = s_q[idx];
    bi         = b_q[idx];
    d_bit      = si ^ bi ^ borrow;
    borrow_nxt = (~si & (bi | borrow)) | (bi & borrow);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      b_q       <= '0;
      k_q       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      d_q       <= '0;
      out_valid <= 1'b0;
      a         <= '0;
      enca      <= '0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s_q    <= s;
            b_q    <= {1'b0, b};
            k_q    <= k;
            borrow <= c;
            idx    <= '0;
            state  <= SUB;
          end
        end
        SUB: begin
          d_q[idx] <= d_bit;
          borrow   <= borrow_nxt;
          idx      <= idx + 1'b1;
          if (idx == LAST) state <= UNMASK;
        end
        UNMASK: begin
          enca      <= d_q[W-1:0];
          a         <= d_q[W-1:0] ^ k_q;
          // Final borrow means a negative difference; d[W] means it reached 2^W.
          range_err <= borrow | d_q[W];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
